rst_decipher: RTL

Inverse stage of `rst_cipher`. It consumes the 16-bit two-character ciphertext symbols that `rst_cipher` produces and recovers one plaintext character per valid symbol. It rebuilds the same 6×6 rotating substitution table from the same 12-character key, and rotates it in lock-step with the encoder. It sits directly downstream of `rst_cipher` on the receive path and is the loop-back check target for the cipher.

---
 rtl/rst_decipher.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rst_decipher.sv
// rtl/rst_decipher.sv - rotating 6x6 substitution decoder, inverse of rst_cipher
module rst_decipher (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [11:0][7:0] key,
    input  logic             ctxt_valid,
    input  logic [15:0]      ctxt_str,
    output logic [7:0]       ptxt_char,
    output logic             ptxt_ready,
    output logic             err_invalid_key,
    output logic             err_invalid_ctxt
);

    typedef enum logic {
        UNINSTALLED = 1'b0,
        INSTALLED   = 1'b1
    } state_t;

    state_t      state;
    logic [2:0]  k;
    logic [7:0]  base_row [6];
    logic [7:0]  base_col [6];

    logic [7:0]  key_row [6];
    logic [7:0]  key_col [6];
    logic [7:0]  tbl_row [6];
    logic [7:0]  tbl_col [6];
    logic        key_valid;
    logic [2:0]  k_eff;
    logic        row_hit;
    logic        col_hit;
    logic [2:0]  row_m;
    logic [2:0]  col_m;
    logic [3:0]  row_sum;
    logic [3:0]  col_sum;
    logic [2:0]  eff_i;
    logic [2:0]  eff_j;
    logic [5:0]  idx;
    logic [7:0]  dec_char;

    function automatic logic is_alnum(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ||
               (c >= 8'h41 && c <= 8'h5A) ||
               (c >= 8'h61 && c <= 8'h7A);
    endfunction

    // String position p lives at key[11-p]; rows take even positions, columns odd.
    always_comb begin
        key_row[0] = key[11];
        key_row[1] = key[1];
        key_row[2] = key[9];
        key_row[3] = key[3];
        key_row[4] = key[7];
        key_row[5] = key[5];
        key_col[0] = key[10];
        key_col[1] = key[0];
        key_col[2] = key[8];
        key_col[3] = key[2];
        key_col[4] = key[6];
        key_col[5] = key[4];
    end

    always_comb begin
        key_valid = 1'b1;
        for (int p = 0; p < 12; p++) begin
            if (!is_alnum(key[p])) key_valid = 1'b0;
            for (int q = p + 1; q < 12; q++) begin
                if (key[p] == key[q]) key_valid = 1'b0;
            end
        end
    end

    // While uninstalled the incoming key is decoded directly with k=0.
    always_comb begin
        for (int m = 0; m < 6; m++) begin
            tbl_row[m] = (state == INSTALLED) ? base_row[m] : key_row[m];
            tbl_col[m] = (state == INSTALLED) ? base_col[m] : key_col[m];
        end
        k_eff = (state == INSTALLED) ? k : 3'd0;
    end

    always_comb begin
        row_hit = 1'b0;
        col_hit = 1'b0;
        row_m   = 3'd0;
        col_m   = 3'd0;
        for (int m = 0; m < 6; m++) begin
            if (tbl_row[m] == ctxt_str[15:8]) begin
                row_hit = 1'b1;
                row_m   = 3'(m);
            end
            if (tbl_col[m] == ctxt_str[7:0]) begin
                col_hit = 1'b1;
                col_m   = 3'(m);
            end
        end
    end

    // Base entry m sits at effective position (m + k) mod 6.
    always_comb begin
        row_sum  = {1'b0, row_m} + {1'b0, k_eff};
        col_sum  = {1'b0, col_m} + {1'b0, k_eff};
        eff_i    = (row_sum >= 4'd6) ? 3'(row_sum - 4'd6) : row_sum[2:0];
        eff_j    = (col_sum >= 4'd6) ? 3'(col_sum - 4'd6) : col_sum[2:0];
        idx      = 6'(eff_i) * 6'd6 + 6'(eff_j);
        dec_char = (idx < 6'd26) ? (8'h41 + {2'b00, idx})
                                 : (8'h30 + {2'b00, idx} - 8'd26);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= UNINSTALLED;
            k                <= 3'd0;
            ptxt_char        <= 8'h00;
            ptxt_ready       <= 1'b0;
            err_invalid_key  <= 1'b0;
            err_invalid_ctxt <= 1'b0;
            for (int m = 0; m < 6; m++) begin
                base_row[m] <= 8'h00;
                base_col[m] <= 8'h00;
            end
        end else begin
            ptxt_ready       <= 1'b0;
            err_invalid_key  <= 1'b0;
            err_invalid_ctxt <= 1'b0;
            if (ctxt_valid) begin
                if (state == UNINSTALLED && !key_valid) begin
                    err_invalid_key <= 1'b1;
                end else begin
                    if (state == UNINSTALLED) begin
                        state <= INSTALLED;
                        k     <= 3'd0;
                        for (int m = 0; m < 6; m++) begin
                            base_row[m] <= key_row[m];
                            base_col[m] <= key_col[m];
                        end
                    end
                    if (row_hit && col_hit) begin
                        ptxt_char  <= dec_char;
                        ptxt_ready <= 1'b1;
                        k          <= (k_eff == 3'd5) ? 3'd0 : k_eff + 3'd1;
                    end else begin
                        err_invalid_ctxt <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
